// File: rtl/garegga_sndcmd_tx_pkg.sv
// Shared definitions for the 68k->sound command transmitter: FSM encoding,
// STATUS bit positions and default timing values.
package garegga_sndcmd_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } snd_state_t;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_TMO   = 3;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_INT_CYC = 8;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TMO_CYC = 1 << 20;

  function automatic logic [7:0] pack_status(input logic tmo, input logic busy,
                                             input logic full, input logic empty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_TMO]   = tmo;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/garegga_cmd_fifo.sv
// DEPTH x 8 synchronous show-ahead FIFO with wrap-bit pointers and registered
// empty/full. A push while full is accepted only when a pop shares the cycle.
module garegga_cmd_fifo
  import garegga_sndcmd_tx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] wr_nxt_s;
  logic [AW:0] rd_nxt_s;
  logic        empty_r;
  logic        full_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Qualify strobes and compute next pointers
  always_comb begin
    do_pop_s  = pop & ~empty_r;
    do_push_s = push & (~full_r | do_pop_s);
    if (do_push_s) begin
      wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    if (do_pop_s) begin
      rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
  end

  // Pointer and flag registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      empty_r  <= (wr_nxt_s == rd_nxt_s);
      full_r   <= (wr_nxt_s[AW] != rd_nxt_s[AW]) &&
                  (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
    end
  end

  // Storage; a write into the slot being popped is safe because dout is read before the edge
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r[AW-1:0]];
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/garegga_sndcmd_tx.sv
// 68k-side transmitter for the main->sound command channel (CLK96 domain).
// Optional build macro SNDCMD_TIMEOUT_EN abandons unacknowledged commands.
module garegga_sndcmd_tx
  import garegga_sndcmd_tx_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int INT_CYC = DEF_INT_CYC,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic       CLK96,
  input  logic       RESET96,
  input  logic       CPU_WR,
  input  logic [7:0] CPU_DIN,
  input  logic       CPU_RD,
  output logic [7:0] STATUS,
  output logic [7:0] SOUNDLATCH,
  output logic       Z80INT,
  input  logic       WAIT
);

  localparam int CNT_MAX = (INT_CYC > SETTLE) ? INT_CYC : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  snd_state_t       state_r;
  snd_state_t       state_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n_s;
  logic [7:0]       latch_r;
  logic [7:0]       latch_n_s;
  logic             int_r;
  logic             int_n_s;
  logic             pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             tmo_hit_s;
  logic             tmo_s;

  garegga_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK96),
    .RST   (RESET96),
    .push  (CPU_WR),
    .pop   (pop_s),
    .din   (CPU_DIN),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    latch_n_s = latch_r;
    int_n_s   = int_r;
    pop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          latch_n_s = fifo_dout_s;
          int_n_s   = 1'b1;
          cnt_n_s   = {CNT_W{1'b0}};
          state_n_s = ST_PULSE;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == CNT_W'(INT_CYC - 1)) begin
          int_n_s   = 1'b0;
          cnt_n_s   = {CNT_W{1'b0}};
          state_n_s = ST_SETTLE;
        end else begin
          cnt_n_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE - 1)) begin
          cnt_n_s   = {CNT_W{1'b0}};
          state_n_s = ST_ACK;
        end else begin
          cnt_n_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ACK: begin
        // A WAIT that already fell during SETTLE counts as the acknowledge
        if (!WAIT || tmo_hit_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_ACK;
        end
      end
      default: begin
        int_n_s   = 1'b0;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      latch_r <= 8'h00;
      int_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      latch_r <= latch_n_s;
      int_r   <= int_n_s;
    end
  end

`ifdef SNDCMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tmo_r;

  assign tmo_hit_s = (state_r == ST_ACK) && WAIT &&
                     (tmo_cnt_r == TMO_W'(TMO_CYC - 1));

  // Ack-wait counter, restarted on every entry to ACK
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r != ST_ACK) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous status read
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      tmo_r <= 1'b0;
    end else if (tmo_hit_s) begin
      tmo_r <= 1'b1;
    end else if (CPU_RD) begin
      tmo_r <= 1'b0;
    end else begin
      tmo_r <= tmo_r;
    end
  end

  assign tmo_s = tmo_r;
`else
  logic        unused_rd_s;
  logic [31:0] unused_tmo_s;

  assign unused_rd_s  = CPU_RD;
  assign unused_tmo_s = 32'(TMO_CYC);
  assign tmo_hit_s    = 1'b0;
  assign tmo_s        = 1'b0;
`endif

  assign STATUS     = pack_status(tmo_s, (state_r != ST_IDLE), fifo_full_s, fifo_empty_s);
  assign SOUNDLATCH = latch_r;
  assign Z80INT     = int_r;

endmodule

// File: tb/tb_garegga_sndcmd_tx.sv
// Scoreboard bench for garegga_sndcmd_tx: a sound-side model raises WAIT on each
// Z80INT rise, and a monitor checks every delivered byte against a queue.
module tb_garegga_sndcmd_tx;

  localparam int INT_CYC = 8;

  logic       CLK96;
  logic       RESET96;
  logic       CPU_WR;
  logic [7:0] CPU_DIN;
  logic       CPU_RD;
  logic [7:0] STATUS;
  logic [7:0] SOUNDLATCH;
  logic       Z80INT;
  logic       WAIT;

  int         n_checks;
  int         n_errors;
  int         n_rises;
  int         ack_delay;
  logic       ack_never;
  logic [7:0] exp_q [$];

  garegga_sndcmd_tx #(.DEPTH(4), .INT_CYC(INT_CYC), .SETTLE(2), .TMO_CYC(64)) dut (
    .CLK96      (CLK96),
    .RESET96    (RESET96),
    .CPU_WR     (CPU_WR),
    .CPU_DIN    (CPU_DIN),
    .CPU_RD     (CPU_RD),
    .STATUS     (STATUS),
    .SOUNDLATCH (SOUNDLATCH),
    .Z80INT     (Z80INT),
    .WAIT       (WAIT)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1; the byte is sampled on the next rising edge
  task automatic wr(input logic [7:0] b, input bit accept);
    CPU_DIN = b;
    CPU_WR  = 1'b1;
    if (accept) exp_q.push_back(b);
    @(posedge CLK96);
    #1 CPU_WR = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int k;
    k = 0;
    while (!(STATUS == 8'h01 && exp_q.size() == 0) && k < limit) begin
      @(negedge CLK96);
      k++;
    end
    chk(nm, 32'(k < limit), 32'd1);
  endtask

  // Sound-side model: WAIT set by the Z80INT edge, cleared ack_delay cycles later
  initial begin
    logic int_q;
    int   wcnt;
    WAIT  = 1'b0;
    int_q = 1'b0;
    wcnt  = 0;
    forever begin
      @(posedge CLK96);
      #1;
      if (RESET96) begin
        WAIT = 1'b0;
        wcnt = 0;
      end else if (Z80INT && !int_q) begin
        WAIT = 1'b1;
        wcnt = ack_delay;
      end else if (WAIT && !ack_never) begin
        if (wcnt <= 1) WAIT = 1'b0;
        else wcnt--;
      end
      int_q = Z80INT;
    end
  end

  // Monitor: compare each presented command, its pulse width and latch stability
  initial begin
    logic       prev;
    int         hi;
    logic [7:0] held;
    logic [7:0] e;
    prev = 1'b0;
    hi   = 0;
    held = 8'h00;
    forever begin
      @(negedge CLK96);
      if (Z80INT && !prev) begin
        n_rises++;
        held = SOUNDLATCH;
        hi   = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cmd: got %0h, expected none (t=%0t)", SOUNDLATCH, $time);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_byte", 32'(SOUNDLATCH), 32'(e));
        end
      end else if (Z80INT) begin
        hi++;
      end else if (prev) begin
        chk("int_width", 32'(hi), 32'(INT_CYC));
        chk("latch_hold", 32'(SOUNDLATCH), 32'(held));
      end
      prev = Z80INT;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks  = 0;
    n_errors  = 0;
    n_rises   = 0;
    ack_delay = 20;
    ack_never = 1'b0;
    RESET96   = 1'b1;
    CPU_WR    = 1'b0;
    CPU_DIN   = 8'h00;
    CPU_RD    = 1'b0;
    repeat (3) @(posedge CLK96);
    #1 RESET96 = 1'b0;
    @(negedge CLK96);
    chk("reset_status", 32'(STATUS), 32'h01);
    chk("reset_latch", 32'(SOUNDLATCH), 32'h00);
    chk("reset_int", 32'(Z80INT), 32'h0);

    // 1: single byte, 2-cycle latency, ack after 20 cycles
    @(posedge CLK96);
    #1;
    wr(8'h5A, 1'b1);
    @(negedge CLK96);
    chk("latch_before_pop", 32'(SOUNDLATCH), 32'h00);
    chk("int_before_pop", 32'(Z80INT), 32'h0);
    @(negedge CLK96);
    chk("latch_2cyc", 32'(SOUNDLATCH), 32'h5A);
    chk("int_with_latch", 32'(Z80INT), 32'h1);
    k = 0;
    while (WAIT && k < 100) begin
      @(negedge CLK96);
      k++;
    end
    chk("busy_at_wait_fall", 32'(STATUS), 32'h05);
    @(negedge CLK96);
    chk("idle_after_ack", 32'(STATUS), 32'h01);

    // 2+3: fill behind a pending command, drop on full, push during pop from full
    ack_delay = 40;
    @(posedge CLK96);
    #1;
    wr(8'hA0, 1'b1);
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    wr(8'h44, 1'b1);
    @(negedge CLK96);
    chk("full_after_4", 32'(STATUS), 32'h06);
    wr(8'h55, 1'b0);
    @(negedge CLK96);
    chk("full_after_drop", 32'(STATUS), 32'h06);
    k = 0;
    while (STATUS[2] && k < 200) begin
      @(negedge CLK96);
      k++;
    end
    chk("idle_full", 32'(STATUS), 32'h02);
    CPU_DIN = 8'h66;
    CPU_WR  = 1'b1;
    exp_q.push_back(8'h66);
    @(posedge CLK96);
    #1 CPU_WR = 1'b0;
    @(negedge CLK96);
    chk("full_after_poppush", 32'(STATUS), 32'h06);
    wait_idle("drain_burst", 2000);
    chk("burst_rises", 32'(n_rises), 32'd7);

    // 4: ack arrives before SETTLE ends
    ack_delay = 1;
    wr(8'h77, 1'b1);
    wr(8'h88, 1'b1);
    wait_idle("drain_fast_ack", 500);
    chk("fast_ack_rises", 32'(n_rises), 32'd9);

    // 5: reset while in ACK with three bytes queued
    ack_never = 1'b1;
    @(posedge CLK96);
    #1;
    wr(8'h99, 1'b1);
    wr(8'hAA, 1'b1);
    wr(8'hBB, 1'b1);
    wr(8'hCC, 1'b1);
    repeat (20) @(negedge CLK96);
    chk("ack_with_3_queued", 32'(STATUS), 32'h04);
    RESET96 = 1'b1;
    exp_q.delete();
    @(posedge CLK96);
    @(negedge CLK96);
    chk("rst_int", 32'(Z80INT), 32'h0);
    chk("rst_status", 32'(STATUS), 32'h01);
    chk("rst_latch", 32'(SOUNDLATCH), 32'h00);
    RESET96   = 1'b0;
    ack_never = 1'b0;
    repeat (40) @(negedge CLK96);
    chk("no_send_after_reset", 32'(n_rises), 32'd10);
    chk("idle_after_reset", 32'(STATUS), 32'h01);

    // 6: WAIT never cleared
    ack_never = 1'b1;
    @(posedge CLK96);
    #1;
    wr(8'hDD, 1'b1);
`ifdef SNDCMD_TIMEOUT_EN
    k = 0;
    while (!Z80INT && k < 20) begin
      @(negedge CLK96);
      k++;
    end
    k = 0;
    while (STATUS[2] && k < 300) begin
      @(negedge CLK96);
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'd74);
    chk("tmo_flag", 32'(STATUS), 32'h09);
    repeat (5) @(negedge CLK96);
    chk("tmo_sticky", 32'(STATUS), 32'h09);
    @(posedge CLK96);
    #1 CPU_RD = 1'b1;
    @(posedge CLK96);
    #1 CPU_RD = 1'b0;
    @(negedge CLK96);
    chk("tmo_cleared", 32'(STATUS), 32'h01);
    ack_never = 1'b0;
    repeat (10) @(negedge CLK96);
`else
    repeat (150) @(negedge CLK96);
    chk("ack_holds", 32'(STATUS), 32'h05);
    ack_never = 1'b0;
    wait_idle("release_ack", 200);
`endif
    chk("final_status", 32'(STATUS), 32'h01);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("total_rises", 32'(n_rises), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
